ex_mem_ctrl: RTL and testbench

EX/MEM pipeline register with an integrated data-cache access controller. It sits between the execute stage and the MEM/WB register. It captures EX results, issues one load or store per captured memory op to the data memory system, and waits for completion. While the access is outstanding it raises DC_Stall, which freezes the ID/EX and upstream registers, and a watchdog bounds the wait.

---
 rtl/ex_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_ex_mem_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_ctrl.sv
// ex_mem_ctrl -- EX/MEM pipeline register with data-cache access controller.
//
// Captures the EX-stage result every cycle the pipeline is not stalled, issues
// one load or store for each captured memory op, and holds DC_Stall high until
// the memory system reports completion or the watchdog expires.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   *_in, nop             EX-stage fields; nop zeroes the captured control bits
//   mem_DataOut/Done/err  response from the memory system
//   mem_Addr/DataIn/Rd/Wr request to the memory system
//   *_out, memData_out    fields handed to MEM/WB
//   DC_Stall              freezes ID/EX and everything upstream
module ex_mem_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] aluResult_in,
    input  logic [15:0] read2Data_in,
    input  logic [2:0]  Write_register_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic        halt_in,
    input  logic        createdump_in,
    input  logic        err_in,
    input  logic        nop,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_Done,
    input  logic        mem_err,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_DataIn,
    output logic        mem_Rd,
    output logic        mem_Wr,
    output logic [15:0] aluResult_out,
    output logic [15:0] memData_out,
    output logic [2:0]  Write_register_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic        halt_out,
    output logic        createdump_out,
    output logic        err_out,
    output logic        DC_Stall
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [15:0] aluResult_q, read2Data_q, memData_q;
    logic [2:0]  wreg_q;
    logic        memwrite_q, memread_q, memtoreg_q, regwrite_q;
    logic        halt_q, dump_q, err_q;

    logic cap, timeout, complete, memop_in, load_done;

    assign timeout  = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT - 1)) && !mem_Done;
    assign complete = (state != S_IDLE) && (mem_Done || timeout);
    assign DC_Stall = (state != S_IDLE) && !complete;
    assign cap      = !DC_Stall;
    assign memop_in = (MemRead_in || MemWrite_in) && !nop;
    assign load_done = complete && memread_q && mem_Done;

    // Next state: on completion the next op is captured in the same edge, so a
    // back-to-back memory op goes straight to ISSUE with no dead cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (memop_in) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (complete) state_nxt = memop_in ? S_ISSUE : S_IDLE;
                else          state_nxt = S_WAIT;
            end
            S_WAIT:  if (complete) state_nxt = memop_in ? S_ISSUE : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_ISSUE) cnt <= '0;
            else if (state == S_WAIT) cnt <= cnt + 1'b1;
        end
    end

    // Pipeline register fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluResult_q <= '0;
            read2Data_q <= '0;
            wreg_q      <= '0;
            memwrite_q  <= 1'b0;
            memread_q   <= 1'b0;
            memtoreg_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            halt_q      <= 1'b0;
            dump_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (cap) begin
            aluResult_q <= aluResult_in;
            read2Data_q <= read2Data_in;
            wreg_q      <= Write_register_in;
            memwrite_q  <= MemWrite_in   & ~nop;
            memread_q   <= MemRead_in    & ~nop;
            memtoreg_q  <= MemtoReg_in;
            regwrite_q  <= RegWrite_in   & ~nop;
            halt_q      <= halt_in       & ~nop;
            dump_q      <= createdump_in & ~nop;
            err_q       <= err_in;
        end
    end

    // Load data: captured on a successful load, forced to zero on timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      memData_q <= '0;
        else if (complete && timeout) memData_q <= '0;
        else if (load_done)           memData_q <= mem_DataOut;
    end

    assign mem_Addr   = aluResult_q;
    assign mem_DataIn = read2Data_q;
    assign mem_Wr     = (state == S_ISSUE) && memwrite_q;
    assign mem_Rd     = (state == S_ISSUE) && memread_q && !memwrite_q;

    assign aluResult_out      = aluResult_q;
    assign Write_register_out = wreg_q;
    assign MemtoReg_out       = memtoreg_q;
    assign RegWrite_out       = regwrite_q;
    assign halt_out           = halt_q;
    assign createdump_out     = dump_q;
    // Bypass so MEM/WB can sample the load data on the completion edge itself
    assign memData_out = load_done ? mem_DataOut : memData_q;
    assign err_out     = err_q || (complete && ((mem_Done && mem_err) || timeout));

endmodule

// File: tb/tb_ex_mem_ctrl.sv
module tb_ex_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] aluResult_in, read2Data_in, mem_DataOut;
    logic [2:0]  Write_register_in;
    logic        MemWrite_in, MemRead_in, MemtoReg_in, RegWrite_in;
    logic        halt_in, createdump_in, err_in, nop, mem_Done, mem_err;
    logic [15:0] mem_Addr, mem_DataIn, aluResult_out, memData_out;
    logic [2:0]  Write_register_out;
    logic        mem_Rd, mem_Wr, MemtoReg_out, RegWrite_out, halt_out;
    logic        createdump_out, err_out, DC_Stall;

    int n_total = 0;
    int n_pass  = 0;

    ex_mem_ctrl #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .aluResult_in(aluResult_in), .read2Data_in(read2Data_in),
        .Write_register_in(Write_register_in), .MemWrite_in(MemWrite_in),
        .MemRead_in(MemRead_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .halt_in(halt_in), .createdump_in(createdump_in), .err_in(err_in), .nop(nop),
        .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_err(mem_err),
        .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
        .aluResult_out(aluResult_out), .memData_out(memData_out),
        .Write_register_out(Write_register_out), .MemtoReg_out(MemtoReg_out),
        .RegWrite_out(RegWrite_out), .halt_out(halt_out), .createdump_out(createdump_out),
        .err_out(err_out), .DC_Stall(DC_Stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one cycle; inputs are then driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        aluResult_in = '0; read2Data_in = '0; Write_register_in = '0;
        MemWrite_in = 0; MemRead_in = 0; MemtoReg_in = 0; RegWrite_in = 0;
        halt_in = 0; createdump_in = 0; err_in = 0; nop = 0;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        mem_DataOut = '0; mem_Done = 0; mem_err = 0;
        #1;
        chk("rst_stall", 16'(DC_Stall), 16'h0);
        chk("rst_rd",    16'(mem_Rd), 16'h0);
        chk("rst_alu",   aluResult_out, 16'h0);
        chk("rst_mdata", memData_out, 16'h0);
        step(); step();
        rst = 1'b0;

        // Non-memory op behaves as a plain register
        aluResult_in = 16'h1234; RegWrite_in = 1; Write_register_in = 3'd3; err_in = 1;
        #1;
        chk("nm_stall0", 16'(DC_Stall), 16'h0);
        step();
        clr_in();
        #1;
        chk("nm_alu",   aluResult_out, 16'h1234);
        chk("nm_rw",    16'(RegWrite_out), 16'h1);
        chk("nm_wreg",  16'(Write_register_out), 16'h3);
        chk("nm_err",   16'(err_out), 16'h1);
        chk("nm_rdwr",  16'({mem_Rd, mem_Wr}), 16'h0);
        chk("nm_stall", 16'(DC_Stall), 16'h0);

        // Load hit: Done in the ISSUE cycle
        aluResult_in = 16'h0040; MemRead_in = 1; MemtoReg_in = 1; RegWrite_in = 1;
        step();
        clr_in();
        mem_Done = 1; mem_DataOut = 16'hBEEF;
        #1;
        chk("lh_rd",    16'(mem_Rd), 16'h1);
        chk("lh_wr",    16'(mem_Wr), 16'h0);
        chk("lh_addr",  mem_Addr, 16'h0040);
        chk("lh_stall", 16'(DC_Stall), 16'h0);
        chk("lh_mdata", memData_out, 16'hBEEF);
        chk("lh_err",   16'(err_out), 16'h0);
        step();
        mem_Done = 0; mem_DataOut = 16'h0;
        #1;
        chk("lh_rd_off", 16'(mem_Rd), 16'h0);
        chk("lh_mdataq", memData_out, 16'hBEEF);
        chk("lh_alu2",   aluResult_out, 16'h0000);

        // Store miss: Done 4 cycles after ISSUE
        aluResult_in = 16'h0080; read2Data_in = 16'h00FF; MemWrite_in = 1;
        step();
        clr_in();
        aluResult_in = 16'h7777; RegWrite_in = 1;
        #1;
        chk("sm_wr",    16'(mem_Wr), 16'h1);
        chk("sm_rd",    16'(mem_Rd), 16'h0);
        chk("sm_din",   mem_DataIn, 16'h00FF);
        chk("sm_addr",  mem_Addr, 16'h0080);
        chk("sm_st0",   16'(DC_Stall), 16'h1);
        step();
        chk("sm_wr1",   16'(mem_Wr), 16'h0);
        chk("sm_st1",   16'(DC_Stall), 16'h1);
        chk("sm_hold",  aluResult_out, 16'h0080);
        step();
        chk("sm_st2",   16'(DC_Stall), 16'h1);
        step();
        chk("sm_st3",   16'(DC_Stall), 16'h1);
        chk("sm_hold3", aluResult_out, 16'h0080);
        aluResult_in = 16'h5555; Write_register_in = 3'd6;
        step();
        mem_Done = 1;
        #1;
        chk("sm_st4",   16'(DC_Stall), 16'h0);
        chk("sm_err",   16'(err_out), 16'h0);
        chk("sm_wr4",   16'(mem_Wr), 16'h0);
        step();
        mem_Done = 0;
        clr_in();
        #1;
        chk("sm_next",  aluResult_out, 16'h5555);
        chk("sm_nwreg", 16'(Write_register_out), 16'h6);
        chk("sm_nrw",   16'(RegWrite_out), 16'h1);
        chk("sm_idle",  16'(DC_Stall), 16'h0);

        // Timeout: TIMEOUT=8, mem_Done never arrives
        aluResult_in = 16'h0100; MemRead_in = 1;
        step();
        clr_in();
        #1;
        chk("to_rd",    16'(mem_Rd), 16'h1);
        chk("to_st0",   16'(DC_Stall), 16'h1);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 8) chk($sformatf("to_st%0d", i), 16'(DC_Stall), 16'h1);
        end
        chk("to_drop",  16'(DC_Stall), 16'h0);
        chk("to_err",   16'(err_out), 16'h1);
        step();
        chk("to_mdata", memData_out, 16'h0000);
        chk("to_err2",  16'(err_out), 16'h0);

        // nop squashes control bits and the memory request
        aluResult_in = 16'h0200; MemRead_in = 1; RegWrite_in = 1; halt_in = 1;
        createdump_in = 1; nop = 1;
        #1;
        chk("nop_st0",  16'(DC_Stall), 16'h0);
        step();
        clr_in();
        #1;
        chk("nop_alu",  aluResult_out, 16'h0200);
        chk("nop_rw",   16'(RegWrite_out), 16'h0);
        chk("nop_halt", 16'(halt_out), 16'h0);
        chk("nop_cd",   16'(createdump_out), 16'h0);
        chk("nop_rd",   16'({mem_Rd, mem_Wr}), 16'h0);
        chk("nop_st",   16'(DC_Stall), 16'h0);

        // Reset in WAIT abandons the access
        aluResult_in = 16'h0300; MemRead_in = 1; RegWrite_in = 1;
        step();
        clr_in();
        step(); step();
        chk("rw_st",    16'(DC_Stall), 16'h1);
        rst = 1;
        #1;
        chk("rw_rd",    16'({mem_Rd, mem_Wr}), 16'h0);
        chk("rw_stall", 16'(DC_Stall), 16'h0);
        chk("rw_alu",   aluResult_out, 16'h0000);
        chk("rw_rw",    16'(RegWrite_out), 16'h0);
        step();
        rst = 0;

        // Fresh load with memory error, then back-to-back store
        aluResult_in = 16'h0400; MemRead_in = 1;
        step();
        clr_in();
        aluResult_in = 16'h0500; read2Data_in = 16'h1111; MemWrite_in = 1;
        halt_in = 1;
        mem_Done = 1; mem_err = 1; mem_DataOut = 16'hCAFE;
        #1;
        chk("fl_rd",    16'(mem_Rd), 16'h1);
        chk("fl_addr",  mem_Addr, 16'h0400);
        chk("fl_err",   16'(err_out), 16'h1);
        chk("fl_mdata", memData_out, 16'hCAFE);
        chk("fl_stall", 16'(DC_Stall), 16'h0);
        step();
        clr_in();
        mem_Done = 0; mem_err = 0; mem_DataOut = 16'h0;
        #1;
        chk("bb_wr",    16'(mem_Wr), 16'h1);
        chk("bb_addr",  mem_Addr, 16'h0500);
        chk("bb_din",   mem_DataIn, 16'h1111);
        chk("bb_halt",  16'(halt_out), 16'h1);
        chk("bb_mdata", memData_out, 16'hCAFE);
        chk("bb_err",   16'(err_out), 16'h0);
        chk("bb_st",    16'(DC_Stall), 16'h1);
        mem_Done = 1;
        step();
        mem_Done = 0;
        #1;
        chk("bb_idle",  16'(DC_Stall), 16'h0);
        chk("bb_wr0",   16'(mem_Wr), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
